// File: rtl/kbd_pkg.sv
// ============================================================================
// Module   : kbd_pkg
// Summary  : Shared scan-code constants, FSM state, event record, ASCII lookup.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package kbd_pkg;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POP    = 2'd1,
        DECODE = 2'd2
    } kbd_state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       rpt;
    } kbd_evt_t;

    // Scan-code set 2 letter keys; extended codes never map to ASCII.
    function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic ext);
        logic [7:0] a;
        a = 8'h00;
        if (!ext) begin
            case (code)
                8'h1C: a = 8'h41;  8'h32: a = 8'h42;  8'h21: a = 8'h43;
                8'h23: a = 8'h44;  8'h24: a = 8'h45;  8'h2B: a = 8'h46;
                8'h34: a = 8'h47;  8'h33: a = 8'h48;  8'h43: a = 8'h49;
                8'h3B: a = 8'h4A;  8'h42: a = 8'h4B;  8'h4B: a = 8'h4C;
                8'h3A: a = 8'h4D;  8'h31: a = 8'h4E;  8'h44: a = 8'h4F;
                8'h4D: a = 8'h50;  8'h15: a = 8'h51;  8'h2D: a = 8'h52;
                8'h1B: a = 8'h53;  8'h2C: a = 8'h54;  8'h3C: a = 8'h55;
                8'h2A: a = 8'h56;  8'h1D: a = 8'h57;  8'h22: a = 8'h58;
                8'h35: a = 8'h59;  8'h1A: a = 8'h5A;
                default: a = 8'h00;
            endcase
        end
        return a;
    endfunction

endpackage

`default_nettype wire

// File: rtl/kbd_evt_fifo.sv
// ============================================================================
// Module   : kbd_evt_fifo
// Summary  : Small synchronous FIFO of key events with full/empty/drop flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module kbd_evt_fifo
    import kbd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_push,
    input  kbd_evt_t i_evt,
    input  logic     i_pop,
    output kbd_evt_t o_head,
    output logic     o_full,
    output logic     o_empty,
    output logic     o_drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    kbd_evt_t        r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    logic            w_do_push;
    logic            w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_drop    = i_push && !w_do_push;
    assign o_head    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_evt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/kbd_event_ctrl.sv
// ============================================================================
// Module   : kbd_event_ctrl
// Summary  : Turns raw PS/2 scan bytes into buffered make/break/repeat events.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module kbd_event_ctrl
    import kbd_pkg::*;
(
    input  logic       clk,
    input  logic       rest,
    input  logic [7:0] ps2_data,
    input  logic       ps2_ready,
    input  logic       ps2_overflow,
    output logic       ps2_nextdata_n,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic       evt_repeat,
    output logic [7:0] evt_ascii,
    output logic [7:0] press_cnt,
    output logic       err_sticky
);

    kbd_state_t r_state;
    logic [7:0] r_byte;
    logic       r_ext;
    logic       r_brk;
    logic       r_held_valid;
    logic [7:0] r_held_code;
    logic       r_held_ext;
    logic       r_nextdata_n;
    logic [7:0] r_press_cnt;
    logic       r_err;

    logic       w_is_prefix;
    logic       w_held_match;
    logic       w_push;
    kbd_evt_t   w_evt;
    kbd_evt_t   w_head;
    logic       w_full;
    logic       w_empty;
    logic       w_drop;
    logic       w_pop;

    assign w_is_prefix  = (r_byte == SC_EXT) || (r_byte == SC_BRK);
    assign w_held_match = r_held_valid && (r_held_code == r_byte) && (r_held_ext == r_ext);
    assign w_push       = (r_state == DECODE) && !w_is_prefix;

    assign w_evt.code = r_byte;
    assign w_evt.ext  = r_ext;
    assign w_evt.brk  = r_brk;
    assign w_evt.rpt  = !r_brk && w_held_match;

    assign w_pop = evt_valid && evt_ready;

    kbd_evt_fifo #(
        .DEPTH (4)
    ) u_fifo (
        .clk     (clk),
        .rst     (rest),
        .i_push  (w_push),
        .i_evt   (w_evt),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );

    // The pop strobe is a register set on entry to POP, so it never depends
    // combinationally on the receiver inputs.
    always_ff @(posedge clk) begin
        if (rest) begin
            r_state      <= IDLE;
            r_byte       <= 8'h00;
            r_ext        <= 1'b0;
            r_brk        <= 1'b0;
            r_held_valid <= 1'b0;
            r_held_code  <= 8'h00;
            r_held_ext   <= 1'b0;
            r_nextdata_n <= 1'b1;
            r_press_cnt  <= 8'h00;
            r_err        <= 1'b0;
        end else begin
            if (ps2_overflow || w_drop) begin
                r_err <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (ps2_ready) begin
                        r_byte       <= ps2_data;
                        r_nextdata_n <= 1'b0;
                        r_state      <= POP;
                    end
                end
                POP: begin
                    r_nextdata_n <= 1'b1;
                    r_state      <= DECODE;
                end
                DECODE: begin
                    r_state <= IDLE;
                    if (r_byte == SC_EXT) begin
                        r_ext <= 1'b1;
                    end else if (r_byte == SC_BRK) begin
                        r_brk <= 1'b1;
                    end else begin
                        r_ext <= 1'b0;
                        r_brk <= 1'b0;
                        // Breaks count even if the FIFO drops the event.
                        if (r_brk) begin
                            r_press_cnt <= r_press_cnt + 8'd1;
                            if (w_held_match) begin
                                r_held_valid <= 1'b0;
                            end
                        end else begin
                            r_held_valid <= 1'b1;
                            r_held_code  <= r_byte;
                            r_held_ext   <= r_ext;
                        end
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_nextdata_n <= 1'b1;
                end
            endcase
        end
    end

    assign ps2_nextdata_n = r_nextdata_n;
    assign press_cnt      = r_press_cnt;
    assign err_sticky     = r_err;

    assign evt_valid  = !w_empty;
    assign evt_code   = evt_valid ? w_head.code : 8'h00;
    assign evt_ext    = evt_valid && w_head.ext;
    assign evt_break  = evt_valid && w_head.brk;
    assign evt_repeat = evt_valid && w_head.rpt;
    assign evt_ascii  = evt_valid ? scan_to_ascii(w_head.code, w_head.ext) : 8'h00;

    logic w_unused;
    assign w_unused = w_full;

endmodule

`default_nettype wire

// File: tb/tb_kbd_event_ctrl.sv
// ============================================================================
// Module   : tb_kbd_event_ctrl
// Summary  : Self-checking bench for kbd_event_ctrl with a modelled receiver FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_kbd_event_ctrl;

    logic       clk = 1'b0;
    logic       rest;
    logic [7:0] ps2_data;
    logic       ps2_ready;
    logic       ps2_overflow;
    logic       ps2_nextdata_n;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       evt_repeat;
    logic [7:0] evt_ascii;
    logic [7:0] press_cnt;
    logic       err_sticky;

    always #5 clk = ~clk;

    kbd_event_ctrl dut (
        .clk            (clk),
        .rest           (rest),
        .ps2_data       (ps2_data),
        .ps2_ready      (ps2_ready),
        .ps2_overflow   (ps2_overflow),
        .ps2_nextdata_n (ps2_nextdata_n),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_code       (evt_code),
        .evt_ext        (evt_ext),
        .evt_break      (evt_break),
        .evt_repeat     (evt_repeat),
        .evt_ascii      (evt_ascii),
        .press_cnt      (press_cnt),
        .err_sticky     (err_sticky)
    );

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       rpt;
        logic [7:0] ascii;
    } obs_t;

    typedef struct {
        logic [7:0] din;
        logic       emits;
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       rpt;
        logic [7:0] ascii;
        logic [7:0] press;
    } vec_t;

    obs_t       cap[$];
    logic [7:0] rxq[$];
    int         n_checks   = 0;
    int         n_pass     = 0;
    int         bytes_fed  = 0;
    int         pulses     = 0;
    int         bad_pulses = 0;
    logic       prev_low   = 1'b0;

    // Receiver model pops on the strobe; event sink records every handshake.
    always @(negedge clk) begin
        obs_t o;
        if (ps2_nextdata_n == 1'b0) begin
            pulses++;
            if (prev_low) bad_pulses++;
            if (rxq.size() > 0) rxq.delete(0);
        end
        prev_low = (ps2_nextdata_n == 1'b0);
        if (evt_valid && evt_ready) begin
            o.code = evt_code; o.ext = evt_ext; o.brk = evt_break;
            o.rpt = evt_repeat; o.ascii = evt_ascii;
            cap.push_back(o);
        end
        ps2_ready = (rxq.size() != 0);
        ps2_data  = ps2_ready ? rxq[0] : 8'h00;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] b);
        rxq.push_back(b);
        bytes_fed++;
        ps2_ready = 1'b1;
        ps2_data  = rxq[0];
    endtask

    task automatic wait_caps(input string nm, input int n, input int lim);
        int k;
        k = 0;
        while (cap.size() < n && k < lim) begin
            cycles(1);
            k++;
        end
        chk(nm, cap.size(), n);
    endtask

    task automatic do_reset();
        rest = 1'b1;
        cycles(2);
        rest = 1'b0;
        cycles(1);
    endtask

    vec_t       tbl[13];
    logic [7:0] ov_in[6];
    logic [7:0] ov_code[4];
    logic [7:0] ov_ascii[4];

    initial begin
        obs_t ev;
        int   lat;
        logic [7:0] held_code;

        tbl[0]  = '{8'h1C, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 8'h41, 8'd0};
        tbl[1]  = '{8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0};
        tbl[2]  = '{8'h1C, 1'b1, 8'h1C, 1'b0, 1'b1, 1'b0, 8'h41, 8'd1};
        tbl[3]  = '{8'hE0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'd1};
        tbl[4]  = '{8'h75, 1'b1, 8'h75, 1'b1, 1'b0, 1'b0, 8'h00, 8'd1};
        tbl[5]  = '{8'hE0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'd1};
        tbl[6]  = '{8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'd1};
        tbl[7]  = '{8'h75, 1'b1, 8'h75, 1'b1, 1'b1, 1'b0, 8'h00, 8'd2};
        tbl[8]  = '{8'h1C, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 8'h41, 8'd2};
        tbl[9]  = '{8'h1C, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b1, 8'h41, 8'd2};
        tbl[10] = '{8'h1C, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b1, 8'h41, 8'd2};
        tbl[11] = '{8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'd2};
        tbl[12] = '{8'h1C, 1'b1, 8'h1C, 1'b0, 1'b1, 1'b0, 8'h41, 8'd3};

        ov_in    = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};
        ov_code  = '{8'h15, 8'h1D, 8'h24, 8'h2D};
        ov_ascii = '{8'h51, 8'h57, 8'h45, 8'h52};

        rest = 1'b1; ps2_overflow = 1'b0; evt_ready = 1'b1;
        ps2_ready = 1'b0; ps2_data = 8'h00;
        cycles(3);

        chk("rst nextdata_n", ps2_nextdata_n, 1);
        chk("rst evt_valid", evt_valid, 0);
        chk("rst evt_code", evt_code, 0);
        chk("rst evt_ascii", evt_ascii, 0);
        chk("rst ext/brk/rpt", {evt_ext, evt_break, evt_repeat}, 0);
        chk("rst press_cnt", press_cnt, 0);
        chk("rst err_sticky", err_sticky, 0);
        rest = 1'b0;
        cycles(1);

        // Make/break, extended key and typematic repeat, one byte per row.
        cap.delete();
        for (int i = 0; i < 13; i++) begin
            feed(tbl[i].din);
            cycles(6);
            if (tbl[i].emits) begin
                chk($sformatf("row%0d evcount", i), cap.size(), 1);
                if (cap.size() > 0) begin
                    ev = cap.pop_front();
                    chk($sformatf("row%0d code", i), ev.code, tbl[i].code);
                    chk($sformatf("row%0d ext", i), ev.ext, tbl[i].ext);
                    chk($sformatf("row%0d brk", i), ev.brk, tbl[i].brk);
                    chk($sformatf("row%0d rpt", i), ev.rpt, tbl[i].rpt);
                    chk($sformatf("row%0d ascii", i), ev.ascii, tbl[i].ascii);
                end
            end else begin
                chk($sformatf("row%0d noevent", i), cap.size(), 0);
            end
            chk($sformatf("row%0d press_cnt", i), press_cnt, tbl[i].press);
        end

        // Event FIFO overflow with the consumer stalled.
        chk("pre-ovf err_sticky", err_sticky, 0);
        evt_ready = 1'b0;
        cap.delete();
        for (int i = 0; i < 6; i++) feed(ov_in[i]);
        cycles(30);
        chk("ovf err_sticky", err_sticky, 1);
        chk("ovf evt_valid", evt_valid, 1);
        chk("ovf head code", evt_code, 8'h15);
        held_code = evt_code;
        cycles(3);
        chk("stall head stable", evt_code, held_code);
        evt_ready = 1'b1;
        wait_caps("ovf drain count", 4, 20);
        for (int i = 0; i < 4 && i < cap.size(); i++) begin
            chk($sformatf("ovf drain%0d code", i), cap[i].code, ov_code[i]);
            chk($sformatf("ovf drain%0d ascii", i), cap[i].ascii, ov_ascii[i]);
        end
        cycles(2);
        chk("ovf drained empty", evt_valid, 0);
        chk("ovf extra events", cap.size(), 4);

        // Receiver overflow flag sets err_sticky; only reset clears it.
        do_reset();
        chk("post-rst err", err_sticky, 0);
        ps2_overflow = 1'b1;
        cycles(1);
        ps2_overflow = 1'b0;
        cycles(3);
        chk("rx ovf err", err_sticky, 1);
        do_reset();
        chk("rst clears err", err_sticky, 0);

        // Reset after a lone prefix discards it; check minimum latency too.
        feed(8'hE0);
        feed(8'hF0);
        cycles(10);
        chk("prefix noevent", evt_valid, 0);
        do_reset();
        cap.delete();
        evt_ready = 1'b0;
        feed(8'h1C);
        lat = 0;
        while (!evt_valid && lat < 10) begin
            cycles(1);
            lat++;
        end
        chk("ready->valid latency", lat, 3);
        chk("post-rst brk", evt_break, 0);
        chk("post-rst ext", evt_ext, 0);
        chk("post-rst code", evt_code, 8'h1C);
        chk("post-rst ascii", evt_ascii, 8'h41);
        chk("post-rst press", press_cnt, 0);
        evt_ready = 1'b1;
        cycles(2);

        // press_cnt wraps after 256 completed presses.
        do_reset();
        cap.delete();
        for (int i = 0; i < 256; i++) begin
            feed(8'h32); feed(8'hF0); feed(8'h32);
        end
        wait_caps("wrap event count", 512, 4000);
        cycles(4);
        chk("wrap press_cnt", press_cnt, 8'h00);
        chk("wrap err_sticky", err_sticky, 0);
        if (cap.size() > 0) chk("wrap last brk", cap[cap.size()-1].brk, 1);
        feed(8'h32); feed(8'hF0); feed(8'h32);
        cycles(15);
        chk("wrap+1 press_cnt", press_cnt, 8'h01);

        chk("strobe width", bad_pulses, 0);
        chk("strobe count", pulses, bytes_fed);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
